arr_stim: RTL and testbench
===========================

Name: arr_stim

Overview:
- Stimulus generator sitting directly upstream of each arr comparator in duv.
- Drives the sig0/sig1 pair that arr compares every posedge.
- Runs a programmed number of pseudo-random vectors from a 32-bit LFSR.
- Can corrupt sig1 on one chosen vector so the downstream mismatch error path is exercised. Reports busy/done back to the test.

Parameters:
- LENGTH, 1, vector width; legal 1..255, matching arr LENGTH.
- SEED, 32'h0000_0001, LFSR load value at reset and at each start; must be non-zero.

Ports:
- arr_stim_clk_ip  input  1  clock, driven from sim_ctrl clock output.
- arr_stim_rst_n_ip  input  1  reset, asynchronous assert, active-low.
- arr_stim_start_ip  input  1  start pulse; sampled only in IDLE or DONE.
- arr_stim_count_ip  input  32  number of vectors to issue; sampled with start.
- arr_stim_inject_ip  input  32  1-based vector index to corrupt; 0 = none; sampled with start.
- arr_stim_mask_ip  input  LENGTH  XOR mask applied to sig1 on the injected vector; sampled with start.
- arr_stim_sig0_op  output  LENGTH  reference vector to arr sig0.
- arr_stim_sig1_op  output  LENGTH  compare vector to arr sig1.
- arr_stim_valid_op  output  1  high while sig0/sig1 carry a live vector.
- arr_stim_busy_op  output  1  high in RUN.
- arr_stim_done_op  output  1  high in DONE.
- arr_stim_issued_op  output  32  vectors issued since last start.

Behaviour:
- Reset (async, rst_n low): state IDLE; lfsr=SEED; sig0=sig1=0; valid=busy=done=0; issued=0; latched count/inject/mask=0. Deassertion takes effect at the next posedge.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and count!=0:
  - latch count, inject, mask; lfsr=SEED; issued=0; done=0; go to RUN.
  - First vector appears on outputs the cycle after the start edge (1-cycle latency).
- IDLE/DONE with start=1 and count==0: go to DONE directly; issued=0; valid stays 0.
- RUN, each cycle:
  - sig0[j] = lfsr[j mod 32] for j = 0..LENGTH-1.
  - sig1 = sig0 XOR (mask if issued+1 == inject, else 0).
  - valid=1; issued increments by 1.
  - LFSR advances Galois right-shift: if lfsr[0], lfsr = (lfsr>>1) ^ 32'h8020_0003, else lfsr = lfsr>>1.
- Vector k (1-based) uses the LFSR state after k-1 advances from SEED.
- When issued reaches count on that edge: go to DONE. In DONE: valid=0, sig0/sig1 hold the last values, issued holds.
- start in RUN is ignored; latched parameters are not re-sampled.
- inject > count: no corruption occurs.
- inject == 0: no corruption.
- mask == 0 with a valid inject: sig1 == sig0 on that vector; no special case.
- issued is 32-bit; count=2^32-1 must not wrap before DONE.
- Reset mid-RUN: immediate return to the reset values above. No partial vector is held, and no done pulse is produced.
- When valid=0, sig0==sig1 holds at all times, so a free-running arr never flags an error outside a run.

Test Plan:
- LENGTH=8, SEED=1, start, count=3, inject=0:
  - sig0 = 8'h01, 8'h03, 8'h02 on consecutive cycles; sig1 equal each cycle.
  - done rises on the cycle after vector 3; issued=3.
- Same setup with inject=2, mask=8'h80:
  - sig1 = 8'h01, 8'h83, 8'h02; arr flags exactly one error, on vector 2.
- start with count=0: DONE next cycle; valid never asserts; issued=0.
- LENGTH=40, SEED=1, count=1: sig0 = 40'h01_0000_0001 (bit 32 mirrors lfsr bit 0).
- rst_n asserted low asynchronously mid-RUN at issued=5 of count=10:
  - all outputs go to 0 without waiting for a clock edge.
  - A restart with count=2 reproduces vectors 1-2 from SEED.
- start pulsed during RUN (count=4): ignored; exactly 4 vectors issued; then restart from DONE runs correctly.

Source files
------------

// File: rtl/arr_stim.sv
// arr_stim: pseudo-random stimulus generator for an arr comparator.
// Issues a programmed number of vectors taken from a 32-bit Galois LFSR on
// sig0/sig1. One chosen vector can have sig1 corrupted by an XOR mask so
// that the comparator's mismatch path is exercised.
//
// Ports:
//   arr_stim_clk_ip     clock
//   arr_stim_rst_n_ip   asynchronous active-low reset
//   arr_stim_start_ip   start pulse, accepted only in IDLE or DONE
//   arr_stim_count_ip   number of vectors to issue (latched on start)
//   arr_stim_inject_ip  1-based vector index to corrupt, 0 = none (latched)
//   arr_stim_mask_ip    XOR mask applied to sig1 on the injected vector (latched)
//   arr_stim_sig0_op    reference vector
//   arr_stim_sig1_op    compare vector
//   arr_stim_valid_op   sig0/sig1 carry a live vector
//   arr_stim_busy_op    run in progress
//   arr_stim_done_op    run finished
//   arr_stim_issued_op  vectors issued since the last start
module arr_stim #(
    parameter int unsigned LENGTH = 1,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic              arr_stim_clk_ip,
    input  logic              arr_stim_rst_n_ip,
    input  logic              arr_stim_start_ip,
    input  logic [31:0]       arr_stim_count_ip,
    input  logic [31:0]       arr_stim_inject_ip,
    input  logic [LENGTH-1:0] arr_stim_mask_ip,
    output logic [LENGTH-1:0] arr_stim_sig0_op,
    output logic [LENGTH-1:0] arr_stim_sig1_op,
    output logic              arr_stim_valid_op,
    output logic              arr_stim_busy_op,
    output logic              arr_stim_done_op,
    output logic [31:0]       arr_stim_issued_op
);

    localparam int unsigned LFSR_W = 32;
    localparam int unsigned CNT_W  = 32;
    localparam logic [LFSR_W-1:0] POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q,  state_d;
    logic [LFSR_W-1:0]   lfsr_q,   lfsr_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [CNT_W-1:0]    inject_q, inject_d;
    logic [LENGTH-1:0]   mask_q,   mask_d;
    logic [LENGTH-1:0]   sig0_q,   sig0_d;
    logic [LENGTH-1:0]   sig1_q,   sig1_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [CNT_W-1:0]    issued_q, issued_d;

    logic [LENGTH-1:0]   vec_c;
    logic [LFSR_W-1:0]   lfsr_next_c;
    logic                inject_hit_c;

    // Vector bits wrap around the LFSR when LENGTH exceeds 32.
    always_comb begin
        vec_c = '0;
        for (int unsigned j = 0; j < LENGTH; j++) begin
            vec_c[j] = lfsr_q[5'(j % LFSR_W)];
        end
    end

    // Galois right-shift step.
    always_comb begin
        if (lfsr_q[0]) begin
            lfsr_next_c = (lfsr_q >> 1) ^ POLY;
        end else begin
            lfsr_next_c = lfsr_q >> 1;
        end
    end

    // issued_q never exceeds count-1 while a vector is being produced, so +1 cannot wrap.
    assign inject_hit_c = (inject_q != '0) && (CNT_W'(issued_q + CNT_W'(1)) == inject_q);

    // Next-state and output computation.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        count_d  = count_q;
        inject_d = inject_q;
        mask_d   = mask_q;
        sig0_d   = sig0_q;
        sig1_d   = sig1_q;
        issued_d = issued_q;
        valid_d  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arr_stim_start_ip) begin
                    count_d  = arr_stim_count_ip;
                    inject_d = arr_stim_inject_ip;
                    mask_d   = arr_stim_mask_ip;
                    lfsr_d   = SEED;
                    issued_d = '0;
                    state_d  = (arr_stim_count_ip != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (issued_q == count_q) begin
                    // Leaving the run: sig1 falls back to sig0 so an idle
                    // comparator never sees a difference, even if the last
                    // vector was the corrupted one.
                    state_d = ST_DONE;
                    sig1_d  = sig0_q;
                end else begin
                    sig0_d   = vec_c;
                    sig1_d   = inject_hit_c ? (vec_c ^ mask_q) : vec_c;
                    valid_d  = 1'b1;
                    issued_d = CNT_W'(issued_q + CNT_W'(1));
                    lfsr_d   = lfsr_next_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge arr_stim_clk_ip or negedge arr_stim_rst_n_ip) begin
        if (!arr_stim_rst_n_ip) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            count_q  <= '0;
            inject_q <= '0;
            mask_q   <= '0;
            sig0_q   <= '0;
            sig1_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            issued_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            count_q  <= count_d;
            inject_q <= inject_d;
            mask_q   <= mask_d;
            sig0_q   <= sig0_d;
            sig1_q   <= sig1_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            issued_q <= issued_d;
        end
    end

    assign arr_stim_sig0_op   = sig0_q;
    assign arr_stim_sig1_op   = sig1_q;
    assign arr_stim_valid_op  = valid_q;
    assign arr_stim_busy_op   = busy_q;
    assign arr_stim_done_op   = done_q;
    assign arr_stim_issued_op = issued_q;

endmodule

// File: tb/tb_arr_stim.sv
// Bench for arr_stim: an 8-bit and a 40-bit instance driven by directed and
// random runs, checked against a vector-list reference model.
module tb_arr_stim;

    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        s8_start,  s40_start;
    logic [31:0] s8_count,  s40_count;
    logic [31:0] s8_inject, s40_inject;
    logic [7:0]  s8_mask;
    logic [39:0] s40_mask;
    logic [7:0]  o8_sig0,  o8_sig1;
    logic [39:0] o40_sig0, o40_sig1;
    logic        o8_valid, o8_busy, o8_done, o40_valid, o40_busy, o40_done;
    logic [31:0] o8_issued, o40_issued;

    arr_stim #(.LENGTH(8), .SEED(SEED)) u_dut8 (
        .arr_stim_clk_ip    (clk),
        .arr_stim_rst_n_ip  (rst_n),
        .arr_stim_start_ip  (s8_start),
        .arr_stim_count_ip  (s8_count),
        .arr_stim_inject_ip (s8_inject),
        .arr_stim_mask_ip   (s8_mask),
        .arr_stim_sig0_op   (o8_sig0),
        .arr_stim_sig1_op   (o8_sig1),
        .arr_stim_valid_op  (o8_valid),
        .arr_stim_busy_op   (o8_busy),
        .arr_stim_done_op   (o8_done),
        .arr_stim_issued_op (o8_issued)
    );

    arr_stim #(.LENGTH(40), .SEED(SEED)) u_dut40 (
        .arr_stim_clk_ip    (clk),
        .arr_stim_rst_n_ip  (rst_n),
        .arr_stim_start_ip  (s40_start),
        .arr_stim_count_ip  (s40_count),
        .arr_stim_inject_ip (s40_inject),
        .arr_stim_mask_ip   (s40_mask),
        .arr_stim_sig0_op   (o40_sig0),
        .arr_stim_sig1_op   (o40_sig1),
        .arr_stim_valid_op  (o40_valid),
        .arr_stim_busy_op   (o40_busy),
        .arr_stim_done_op   (o40_done),
        .arr_stim_issued_op (o40_issued)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: the vector each instance should be holding while idle.
    logic [63:0] last8  = '0;
    logic [63:0] last40 = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Vector k (1-based) is the LFSR state after k-1 steps from SEED, repeated across the width.
    function automatic logic [63:0] vec_of(input int unsigned k, input int unsigned w);
        logic [31:0] s;
        s = SEED;
        for (int unsigned i = 1; i < k; i++) begin
            s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        end
        return {s, s} & wmask(w);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int unsigned w, input logic st, input logic [31:0] c,
                          input logic [31:0] inj, input logic [63:0] m);
        if (w == 8) begin
            s8_start = st; s8_count = c; s8_inject = inj; s8_mask = m[7:0];
        end else begin
            s40_start = st; s40_count = c; s40_inject = inj; s40_mask = m[39:0];
        end
    endtask

    task automatic sample(input int unsigned w, output logic [63:0] s0, output logic [63:0] s1,
                          output logic v, output logic b, output logic d, output logic [31:0] iss);
        if (w == 8) begin
            s0 = {56'd0, o8_sig0}; s1 = {56'd0, o8_sig1};
            v = o8_valid; b = o8_busy; d = o8_done; iss = o8_issued;
        end else begin
            s0 = {24'd0, o40_sig0}; s1 = {24'd0, o40_sig1};
            v = o40_valid; b = o40_busy; d = o40_done; iss = o40_issued;
        end
    endtask

    task automatic chk_idle(input string tag, input int unsigned w, input logic exp_done,
                            input logic [31:0] exp_iss);
        logic [63:0] s0, s1, last;
        logic v, b, d;
        logic [31:0] iss;
        sample(w, s0, s1, v, b, d, iss);
        last = (w == 8) ? last8 : last40;
        chk({tag, " valid"},  64'(v),   64'(0));
        chk({tag, " busy"},   64'(b),   64'(0));
        chk({tag, " done"},   64'(d),   64'(exp_done));
        chk({tag, " issued"}, 64'(iss), 64'(exp_iss));
        chk({tag, " sig0"},   s0,       last);
        chk({tag, " sig1"},   s1,       last);
    endtask

    // One complete run: start, every vector, then the DONE state.
    task automatic run(input int unsigned w, input logic [31:0] c, input logic [31:0] inj,
                       input logic [63:0] m, input logic poke_start);
        logic [63:0] s0, s1, exp0, exp1;
        logic v, b, d;
        logic [31:0] iss;
        string tg;
        set_in(w, 1'b1, c, inj, m);
        tick();
        // Scramble the inputs: latched values must be used from here on.
        set_in(w, 1'b0, $urandom, $urandom, {$urandom, $urandom});
        sample(w, s0, s1, v, b, d, iss);
        tg = $sformatf("w%0d c%0d start", w, c);
        chk({tg, " valid"},  64'(v),   64'(0));
        chk({tg, " busy"},   64'(b),   64'(c != 0));
        chk({tg, " done"},   64'(d),   64'(c == 0));
        chk({tg, " issued"}, 64'(iss), 64'(0));
        if (c == 0) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                chk_idle($sformatf("w%0d c0 hold%0d", w, i), w, 1'b1, 32'd0);
            end
        end else begin
            for (int unsigned k = 1; k <= c; k++) begin
                if (poke_start && k == 2) set_in(w, 1'b1, c + 3, 32'd1, {$urandom, $urandom});
                if (poke_start && k == 3) set_in(w, 1'b0, 32'd0, 32'd0, 64'd0);
                tick();
                exp0 = vec_of(k, w);
                exp1 = (k == inj) ? (exp0 ^ (m & wmask(w))) : exp0;
                sample(w, s0, s1, v, b, d, iss);
                tg = $sformatf("w%0d c%0d k%0d", w, c, k);
                chk({tg, " sig0"},   s0,       exp0);
                chk({tg, " sig1"},   s1,       exp1);
                chk({tg, " valid"},  64'(v),   64'(1));
                chk({tg, " busy"},   64'(b),   64'(1));
                chk({tg, " done"},   64'(d),   64'(0));
                chk({tg, " issued"}, 64'(iss), 64'(k));
                if (w == 8) last8 = exp0; else last40 = exp0;
            end
            set_in(w, 1'b0, 32'd0, 32'd0, 64'd0);
            tick();
            chk_idle($sformatf("w%0d c%0d done", w, c), w, 1'b1, c);
        end
    endtask

    initial begin
        logic [63:0] s0, s1;
        logic v, b, d;
        logic [31:0] iss;
        int unsigned w, c, inj;

        rst_n = 1'b0;
        set_in(8, 1'b0, 32'd0, 32'd0, 64'd0);
        set_in(40, 1'b0, 32'd0, 32'd0, 64'd0);
        #1;
        chk_idle("reset8", 8, 1'b0, 32'd0);
        chk_idle("reset40", 40, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("idle8", 8, 1'b0, 32'd0);

        // Directed cases.
        run(8, 32'd3, 32'd0, 64'd0, 1'b0);
        run(8, 32'd3, 32'd2, 64'h80, 1'b0);
        run(8, 32'd0, 32'd0, 64'd0, 1'b0);
        run(40, 32'd1, 32'd0, 64'd0, 1'b0);
        chk("w40 bit32 mirror", last40, 64'h01_0000_0001);
        run(8, 32'd4, 32'd0, 64'd0, 1'b1);
        run(8, 32'd2, 32'd2, 64'h00, 1'b0);
        run(8, 32'd3, 32'd3, 64'hff, 1'b0);

        // Asynchronous reset in the middle of a run.
        set_in(8, 1'b1, 32'd10, 32'd0, 64'd0);
        tick();
        set_in(8, 1'b0, 32'd0, 32'd0, 64'd0);
        repeat (5) tick();
        sample(8, s0, s1, v, b, d, iss);
        chk("midrun issued", 64'(iss), 64'(5));
        chk("midrun sig0", s0, vec_of(5, 8));
        #2 rst_n = 1'b0;
        #1;
        last8 = '0;
        last40 = '0;
        chk_idle("async rst8", 8, 1'b0, 32'd0);
        chk_idle("async rst40", 40, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_idle("post rst8", 8, 1'b0, 32'd0);
        run(8, 32'd2, 32'd0, 64'd0, 1'b0);

        // Random runs on both widths.
        for (int r = 0; r < 12; r++) begin
            w   = (r % 2 == 0) ? 8 : 40;
            c   = $urandom_range(1, 9);
            inj = $urandom_range(0, c + 2);
            run(w, c, inj, {$urandom, $urandom}, ($urandom_range(0, 1) == 1) && (c >= 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
